// File: rtl/shift_pkg.sv
// Shared definitions for the shift execution unit: op encodings, flag layout
// and tag width.
package shift_pkg;

   localparam int TAG_W = 4;
   localparam int CNT_W = 8;

   localparam int FLG_CF = 0;
   localparam int FLG_ZF = 1;
   localparam int FLG_SF = 2;
   localparam int FLG_OF = 3;

   typedef enum logic [1:0] {
      OP_SHL = 2'b00,
      OP_SHR = 2'b01,
      OP_SAR = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   // Field order matches the {OF, SF, ZF, CF} bus layout and the FLG_* indices.
   typedef struct packed {
      logic of;
      logic sf;
      logic zf;
      logic cf;
   } flags_t;

endpackage

// File: rtl/shift_exec_unit_if.sv
// Issue-side and writeback-side handshake bundle for the shift execution unit.
interface shift_exec_if #(
   parameter int WIDTH = 32
);
   import shift_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           in_op;
   logic [WIDTH-1:0]     in_data;
   logic [CNT_W-1:0]     in_cnt;
   logic [TAG_W-1:0]     in_tag;

   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [TAG_W-1:0]     out_tag;
   logic [3:0]           out_flags;
   logic                 out_flag_we;

   modport master (
      output in_valid, in_op, in_data, in_cnt, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_flags, out_flag_we
   );

   modport slave (
      input  in_valid, in_op, in_data, in_cnt, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_flags, out_flag_we
   );

endinterface

// File: rtl/bit_shift_right.sv
// Logarithmic right barrel shifter with a programmable fill bit; stage s
// shifts by 2**s when amount bit s is set.
module bit_shift_right #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]         i_data,
   input  logic [$clog2(WIDTH)-1:0] i_amt,
   input  logic                     i_sin,
   output logic [WIDTH-1:0]         o_data
);
   localparam int AMT_W = $clog2(WIDTH);

   for (genvar s = 0; s < AMT_W; s++) begin : g_stage
      localparam int SH = 1 << s;
      logic [WIDTH-1:0] w_prev;
      logic [WIDTH-1:0] w_out;

      if (s == 0) begin : g_first
         assign w_prev = i_data;
      end else begin : g_chain
         assign w_prev = g_stage[s-1].w_out;
      end

      assign w_out = i_amt[s] ? WIDTH'({{SH{i_sin}}, w_prev} >> SH) : w_prev;
   end

   assign o_data = g_stage[AMT_W-1].w_out;

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage SHL/SHR/SAR execution unit: S1 captures the micro-op, S2 holds the
// result and x86-style flags. Left shifts reuse the right shifter via bit reversal.
module shift_exec_unit #(
   parameter int WIDTH = 32,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic         clk,
   input  logic         rst,
   shift_exec_if.slave  bus
);
   import shift_pkg::*;

   logic                 r_s1_valid;
   op_e                  r_s1_op;
   logic [WIDTH-1:0]     r_s1_data;
   logic [AMT_W-1:0]     r_s1_cnt;
   logic [TAG_W-1:0]     r_s1_tag;

   logic                 r_s2_valid;
   logic [WIDTH-1:0]     r_s2_data;
   logic [TAG_W-1:0]     r_s2_tag;
   flags_t               r_s2_flags;
   logic                 r_s2_flag_we;

   logic                 w_s2_adv;
   logic                 w_s1_adv;
   logic                 w_in_ready;
   logic                 w_accept;

   logic [WIDTH-1:0]     w_rev_in;
   logic [WIDTH-1:0]     w_sh_in;
   logic                 w_sin;
   logic [WIDTH-1:0]     w_sh_out;
   logic [WIDTH-1:0]     w_rev_out;
   logic [WIDTH-1:0]     w_result;
   logic [AMT_W-1:0]     w_shr_idx;
   logic [AMT_W-1:0]     w_shl_idx;
   logic                 w_is_shl;
   flags_t               w_flags;
   logic                 w_flag_we;
   logic [CNT_W-AMT_W-1:0] w_unused_cnt_hi;

   assign w_s2_adv   = !r_s2_valid || bus.out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_adv;
   assign w_in_ready = !r_s1_valid || w_s2_adv;
   assign w_accept   = bus.in_valid && w_in_ready;

   // Counts wrap by masking; the upper raw count bits are intentionally ignored.
   assign w_unused_cnt_hi = bus.in_cnt[CNT_W-1:AMT_W];

   assign w_is_shl = (r_s1_op == OP_SHL);
   assign w_sin    = (r_s1_op == OP_SAR) ? r_s1_data[WIDTH-1] : 1'b0;
   assign w_sh_in  = w_is_shl ? w_rev_in : r_s1_data;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_rev_in  = '0;
      w_rev_out = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_rev_in[i]  = r_s1_data[WIDTH-1-i];
         w_rev_out[i] = w_sh_out[WIDTH-1-i];
      end
   end

   bit_shift_right #(
      .WIDTH (WIDTH)
   ) u_shr (
      .i_data (w_sh_in),
      .i_amt  (r_s1_cnt),
      .i_sin  (w_sin),
      .o_data (w_sh_out)
   );

   assign w_result  = w_is_shl ? w_rev_out : w_sh_out;

   // Last bit shifted out: data[cnt-1] going right, data[WIDTH-cnt] going left.
   assign w_shr_idx = r_s1_cnt - AMT_W'(1);
   assign w_shl_idx = AMT_W'(0) - r_s1_cnt;

   always_comb begin
      w_flags   = '0;
      w_flag_we = 1'b0;
      if (r_s1_cnt != '0) begin
         w_flag_we = 1'b1;
         unique case (r_s1_op)
            OP_SHL: begin
               w_flags.cf = r_s1_data[w_shl_idx];
               w_flags.of = (r_s1_cnt == AMT_W'(1)) ? (w_result[WIDTH-1] ^ w_flags.cf) : 1'b0;
            end
            OP_SAR: begin
               w_flags.cf = r_s1_data[w_shr_idx];
               w_flags.of = 1'b0;
            end
            default: begin
               w_flags.cf = r_s1_data[w_shr_idx];
               w_flags.of = (r_s1_cnt == AMT_W'(1)) ? r_s1_data[WIDTH-1] : 1'b0;
            end
         endcase
         w_flags.zf = (w_result == '0);
         w_flags.sf = w_result[WIDTH-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so both stages update
   // from pre-edge values and the pipeline shifts cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: payload registers are reset too, because out_data/out_tag/out_flags
         // are architecturally visible as zero while idle after reset.
         r_s1_valid   <= 1'b0;
         r_s1_op      <= OP_SHL;
         r_s1_data    <= '0;
         r_s1_cnt     <= '0;
         r_s1_tag     <= '0;
         r_s2_valid   <= 1'b0;
         r_s2_data    <= '0;
         r_s2_tag     <= '0;
         r_s2_flags   <= '0;
         r_s2_flag_we <= 1'b0;
      end else begin
         if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
         end
         if (w_accept) begin
            r_s1_op   <= op_e'(bus.in_op);
            r_s1_data <= bus.in_data;
            r_s1_cnt  <= bus.in_cnt[AMT_W-1:0];
            r_s1_tag  <= bus.in_tag;
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s1_adv) begin
            r_s2_data    <= w_result;
            r_s2_tag     <= r_s1_tag;
            r_s2_flags   <= w_flags;
            r_s2_flag_we <= w_flag_we;
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_s2_valid;
   assign bus.out_data    = r_s2_data;
   assign bus.out_tag     = r_s2_tag;
   assign bus.out_flags   = r_s2_flags;
   assign bus.out_flag_we = r_s2_flag_we;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed bench for shift_exec_unit: hand-computed vectors for each op, count
// masking, back-to-back throughput, backpressure and mid-flight reset.
module tb_shift_exec_unit;

   localparam int WIDTH = 32;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   int   n_acc;

   shift_exec_if #(.WIDTH(WIDTH)) bus ();

   shift_exec_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_result(input string tag, input logic [31:0] d, input logic [3:0] f,
                                input logic we, input logic [3:0] t);
      check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".data"}, bus.out_data, d);
      check({tag, ".flags"}, 32'(bus.out_flags), 32'(f));
      check({tag, ".we"}, 32'(bus.out_flag_we), 32'(we));
      check({tag, ".tag"}, 32'(bus.out_tag), 32'(t));
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic do_issue(input logic [1:0] op, input logic [31:0] d, input logic [7:0] c,
                           input logic [3:0] t);
      int n;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_data  = d;
      bus.in_cnt   = c;
      bus.in_tag   = t;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("issue_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_single(input string tag, input logic [1:0] op, input logic [31:0] d,
                             input logic [7:0] c, input logic [3:0] t, input logic [31:0] ed,
                             input logic [3:0] ef, input logic ewe);
      do_issue(op, d, c, t);
      check({tag, ".lat1"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      expect_result(tag, ed, ef, ewe, t);
   endtask

   initial begin
      logic [31:0] b2b_data [4];
      logic [3:0]  b2b_flag [4];
      b2b_data = '{32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
      b2b_flag = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};

      n_vec = 0;
      n_err = 0;
      n_acc = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = 2'b00;
      bus.in_data   = '0;
      bus.in_cnt    = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst.in_ready", 32'(bus.in_ready), 32'd1);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.out_data", bus.out_data, 32'd0);
      check("rst.out_tag", 32'(bus.out_tag), 32'd0);
      check("rst.out_flags", 32'(bus.out_flags), 32'd0);
      check("rst.flag_we", 32'(bus.out_flag_we), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single ops, flags {OF,SF,ZF,CF}
      run_single("shr1", 2'b01, 32'h8000_0001, 8'd1, 4'd1, 32'h4000_0000, 4'b1001, 1'b1);
      run_single("sar31", 2'b10, 32'h8000_0000, 8'd31, 4'd2, 32'hFFFF_FFFF, 4'b0100, 1'b1);
      run_single("shl1", 2'b00, 32'h4000_0001, 8'd1, 4'd3, 32'h8000_0002, 4'b1100, 1'b1);
      run_single("shr_zf", 2'b01, 32'h0000_0001, 8'd1, 4'd4, 32'h0000_0000, 4'b0011, 1'b1);
      run_single("mask21", 2'b01, 32'h0000_0004, 8'h21, 4'd5, 32'h0000_0002, 4'b0000, 1'b1);
      run_single("mask20", 2'b01, 32'h0000_0004, 8'h20, 4'd6, 32'h0000_0004, 4'b0000, 1'b0);
      run_single("rsv", 2'b11, 32'h8000_0001, 8'd1, 4'd7, 32'h4000_0000, 4'b1001, 1'b1);
      run_single("shl4", 2'b00, 32'h1234_5678, 8'd4, 4'd8, 32'h2345_6780, 4'b0001, 1'b1);
      @(negedge clk);
      check("idle.out_valid", 32'(bus.out_valid), 32'd0);

      // Back-to-back: SHR 0xF0 by 4..7, tags 0..3, one result per cycle
      for (int i = 0; i < 6; i++) begin
         if (i >= 2)
            expect_result($sformatf("b2b%0d", i - 2), b2b_data[i-2], b2b_flag[i-2], 1'b1,
                          4'(i - 2));
         if (i < 4) begin
            check("b2b.in_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_op    = 2'b01;
            bus.in_data  = 32'h0000_00F0;
            bus.in_cnt   = 8'(i + 4);
            bus.in_tag   = 4'(i);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b.drained", 32'(bus.out_valid), 32'd0);

      // Backpressure: 3 ops offered while out_ready=0, only 2 fit
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_op    = (i == 0) ? 2'b10 : 2'b00;
         bus.in_data  = (i == 0) ? 32'h8000_0000 : 32'h4000_0001;
         bus.in_cnt   = (i == 0) ? 8'd31 : 8'd1;
         bus.in_tag   = 4'(9 + i);
         if (bus.in_ready) n_acc++;
         @(negedge clk);
      end
      if (bus.in_valid && bus.in_ready) n_acc++;
      bus.in_valid = 1'b0;
      check("bp.accepted", 32'(n_acc), 32'd2);
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      expect_result("bp.hold0", 32'hFFFF_FFFF, 4'b0100, 1'b1, 4'd9);
      @(negedge clk);
      expect_result("bp.hold1", 32'hFFFF_FFFF, 4'b0100, 1'b1, 4'd9);
      bus.out_ready = 1'b1;
      @(negedge clk);
      expect_result("bp.second", 32'h8000_0002, 4'b1100, 1'b1, 4'd10);
      @(negedge clk);
      check("bp.drained", 32'(bus.out_valid), 32'd0);
      check("bp.ready_back", 32'(bus.in_ready), 32'd1);

      // Reset with both stages full
      bus.out_ready = 1'b0;
      do_issue(2'b01, 32'h0000_00FF, 8'd1, 4'd12);
      do_issue(2'b01, 32'h0000_00FF, 8'd2, 4'd13);
      check("mrst.s2_full", 32'(bus.out_valid), 32'd1);
      check("mrst.s1_full", 32'(bus.in_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("mrst.out_valid", 32'(bus.out_valid), 32'd0);
      check("mrst.in_ready", 32'(bus.in_ready), 32'd1);
      check("mrst.out_data", bus.out_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mrst.no_stale", 32'(bus.out_valid), 32'd0);
      end
      check("mrst.ready_after", 32'(bus.in_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
